// File: rtl/prn_sched.sv
// prn_sched -- two-requester round-robin scheduler feeding one printer port.
//
// Each requester raises i_reqN with a byte on i_dataN and holds both until
// o_ackN pulses. When the printer is idle (i_rdy=1) the FSM grants one
// requester, strobes o_tr for one cycle with the byte on o_pd, then follows
// the printer's ready line: wait for it to drop (printer busy), then wait for
// it to rise again (byte done). o_pd is held steady for the whole transfer
// because the printer samples it on every busy cycle.
//
// Handshake: i_reqN is a level request that stays high (with i_dataN stable)
// until the cycle after o_ackN is seen; o_ackN is a registered single-cycle
// pulse in the ISSUE cycle. Requests are only sampled in IDLE, so a request
// still high during ISSUE or later cannot cause a second grant.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req0/1, i_data0/1   requester level requests and their bytes
//   o_ack0/1              one-cycle grant pulses (never both high)
//   o_tr, o_pd            printer strobe and data byte
//   i_rdy                 printer ready (1 = idle)
//   o_busy                FSM not in IDLE
//   o_gnt_id              requester owning the current/last transfer
//   o_cnt                 completed-byte counter, wraps 0xFF -> 0x00
//   o_err                 sticky printer-timeout flag
//   o_state               FSM state (0 IDLE, 1 ISSUE, 2 WAIT_BUSY, 3 WAIT_DONE)
//
// Build option: define PRN_SCHED_TIMEOUT_EN to add a 5-bit watchdog on the
// two wait states. Without it o_err is tied to 0 and the waits are unbounded.

module prn_sched (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic [7:0] i_data0,
  output logic       o_ack0,
  input  logic       i_req1,
  input  logic [7:0] i_data1,
  output logic       o_ack1,
  output logic       o_tr,
  output logic [7:0] o_pd,
  input  logic       i_rdy,
  output logic       o_busy,
  output logic       o_gnt_id,
  output logic [7:0] o_cnt,
  output logic       o_err,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state;

  // Requester that wins a two-way tie; flips to the other side on every grant.
  logic rr_pri;

  logic any_req;
  logic win_id;

  always_comb begin
    any_req = i_req0 | i_req1;
    win_id  = (i_req0 & i_req1) ? rr_pri : i_req1;
  end

`ifdef PRN_SCHED_TIMEOUT_EN
  // Cycles spent in the current wait state; cleared on entry to each.
  logic [4:0] wd_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_tr     <= 1'b0;
      o_pd     <= 8'h00;
      o_ack0   <= 1'b0;
      o_ack1   <= 1'b0;
      o_gnt_id <= 1'b0;
      o_cnt    <= 8'h00;
      rr_pri   <= 1'b0;
`ifdef PRN_SCHED_TIMEOUT_EN
      wd_cnt   <= 5'd0;
      o_err    <= 1'b0;
`endif
    end else begin
      o_tr   <= 1'b0;
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rdy && any_req) begin
            state    <= ISSUE;
            o_tr     <= 1'b1;
            o_pd     <= win_id ? i_data1 : i_data0;
            o_gnt_id <= win_id;
            o_ack0   <= ~win_id;
            o_ack1   <= win_id;
            rr_pri   <= ~win_id;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
`ifdef PRN_SCHED_TIMEOUT_EN
          wd_cnt <= 5'd0;
`endif
        end
        WAIT_BUSY: begin
          if (!i_rdy) begin
            state <= WAIT_DONE;
`ifdef PRN_SCHED_TIMEOUT_EN
            wd_cnt <= 5'd0;
          end else if (wd_cnt == 5'd3) begin
            // Fourth cycle in WAIT_BUSY still ready: printer never took the byte.
            state <= IDLE;
            o_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 5'd1;
`endif
          end
        end
        WAIT_DONE: begin
          if (i_rdy) begin
            state <= IDLE;
            o_cnt <= o_cnt + 8'd1;
`ifdef PRN_SCHED_TIMEOUT_EN
          end else if (wd_cnt == 5'd15) begin
            // Sixteenth busy cycle: give up without counting the byte.
            state <= IDLE;
            o_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 5'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef PRN_SCHED_TIMEOUT_EN
  assign o_err = 1'b0;
`endif

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_prn_sched.sv
module tb_prn_sched;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0, i_req1;
  logic [7:0] i_data0, i_data1;
  logic       i_rdy;
  logic       o_ack0, o_ack1, o_tr, o_busy, o_gnt_id, o_err;
  logic [7:0] o_pd, o_cnt;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;

  // Printer model control: 0 = standard 8-busy-cycle printer, 1 = ready tied
  // high, 2 = ready tied low.
  int rdy_mode = 0;
  int busy_left = 0;
  int lead = 0;

  prn_sched dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req0   (i_req0),
    .i_data0  (i_data0),
    .o_ack0   (o_ack0),
    .i_req1   (i_req1),
    .i_data1  (i_data1),
    .o_ack1   (o_ack1),
    .o_tr     (o_tr),
    .o_pd     (o_pd),
    .i_rdy    (i_rdy),
    .o_busy   (o_busy),
    .o_gnt_id (o_gnt_id),
    .o_cnt    (o_cnt),
    .o_err    (o_err),
    .o_state  (o_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Printer: sees the strobe, goes busy two edges later for 8 cycles.
  always @(posedge i_clk) begin
    #1;
    if (rdy_mode == 1) begin
      i_rdy = 1'b1;
    end else if (rdy_mode == 2) begin
      i_rdy = 1'b0;
    end else begin
      if (busy_left != 0) begin
        busy_left = busy_left - 1;
      end else if (lead != 0) begin
        lead = lead - 1;
        if (lead == 0) busy_left = 8;
      end else if (o_tr) begin
        lead = 2;
      end
      i_rdy = (busy_left == 0);
    end
  end

  // Driver tasks
  task automatic apply_reset();
    i_req0  = 1'b0;
    i_req1  = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic wait_ack(input int limit, output bit ok, output bit id);
    ok = 1'b0;
    id = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge i_clk);
      if (o_ack0 || o_ack1) begin
        ok = 1'b1;
        id = o_ack1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < limit; i++) begin
      if (o_state == 2'd0) begin
        ok = 1'b1;
        break;
      end
      n++;
      @(negedge i_clk);
    end
  endtask

  // One request from requester id; ok reports grant, identity, byte and completion.
  task automatic do_xfer(input bit id, input logic [7:0] d, output bit ok);
    bit got, gid, idle_ok;
    int n;
    @(negedge i_clk);
    if (id) begin i_req1 = 1'b1; i_data1 = d; end
    else    begin i_req0 = 1'b1; i_data0 = d; end
    wait_ack(30, got, gid);
    ok = got && (gid == id) && (o_pd === d) && (o_gnt_id === id);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    wait_idle(30, idle_ok, n);
    ok = ok && idle_ok;
  endtask

  // Tests
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req0 = 1'b0; i_req1 = 1'b0; i_data0 = 8'h00; i_data1 = 8'h00;
    #3;
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    total++; if (o_tr !== 1'b0) begin bad++; $display("FAIL reset_tr: got %b want 0", o_tr); end
    total++; if (o_pd !== 8'h00) begin bad++; $display("FAIL reset_pd: got %h want 00", o_pd); end
    total++; if ({o_ack0, o_ack1} !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", {o_ack0, o_ack1}); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_gnt_id !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0", o_gnt_id); end
    total++; if (o_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt: got %h want 00", o_cnt); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", o_err); end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_single();
    bit ok, id;
    int n = 0, pd_bad = 0, tr_n = 0, ack_n = 0, busy_bad = 0;
    @(negedge i_clk);
    i_data0 = 8'hA5;
    i_req0  = 1'b1;
    wait_ack(20, ok, id);
    total++; if (!ok) begin bad++; $display("FAIL single_ack: got none want ack within 20 cycles"); end
    total++; if (id !== 1'b0) begin bad++; $display("FAIL single_ack_id: got %b want 0", id); end
    total++; if (o_tr !== 1'b1) begin bad++; $display("FAIL single_tr_with_ack: got %b want 1", o_tr); end
    total++; if (o_ack1 !== 1'b0) begin bad++; $display("FAIL single_ack1: got %b want 0", o_ack1); end
    i_req0 = 1'b0;
    for (int i = 0; i < 40 && o_state != 2'd0; i++) begin
      n++;
      if (o_pd !== 8'hA5) pd_bad++;
      if (o_tr) tr_n++;
      if (o_ack0) ack_n++;
      if (!o_busy) busy_bad++;
      @(negedge i_clk);
    end
    total++; if (n != 11) begin bad++; $display("FAIL single_len: got %0d want 11", n); end
    total++; if (pd_bad != 0) begin bad++; $display("FAIL single_pd_hold: got %0d bad cycles want 0", pd_bad); end
    total++; if (tr_n != 1) begin bad++; $display("FAIL single_tr_pulse: got %0d want 1", tr_n); end
    total++; if (ack_n != 1) begin bad++; $display("FAIL single_ack_pulse: got %0d want 1", ack_n); end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL single_busy: got %0d idle cycles want 0", busy_bad); end
    total++; if (o_cnt !== 8'h01) begin bad++; $display("FAIL single_cnt: got %h want 01", o_cnt); end
    total++; if (o_gnt_id !== 1'b0) begin bad++; $display("FAIL single_gnt: got %b want 0", o_gnt_id); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", o_busy); end
  endtask

  task automatic test_tie();
    bit ok, id, idle_ok;
    bit ids[2];
    logic [7:0] pds[2];
    int n;
    apply_reset();
    i_data0 = 8'h11; i_data1 = 8'h22;
    i_req0 = 1'b1; i_req1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ack(30, ok, id);
      total++; if (!ok) begin bad++; $display("FAIL tie_ack%0d: got none want ack", k); end
      ids[k] = id;
      pds[k] = o_pd;
      if (id) i_req1 = 1'b0;
      else    i_req0 = 1'b0;
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    wait_idle(30, idle_ok, n);
    total++; if (ids[0] !== 1'b0) begin bad++; $display("FAIL tie_first_id: got %b want 0", ids[0]); end
    total++; if (ids[1] !== 1'b1) begin bad++; $display("FAIL tie_second_id: got %b want 1", ids[1]); end
    total++; if (pds[0] !== 8'h11) begin bad++; $display("FAIL tie_first_pd: got %h want 11", pds[0]); end
    total++; if (pds[1] !== 8'h22) begin bad++; $display("FAIL tie_second_pd: got %h want 22", pds[1]); end
    total++; if (o_cnt !== 8'h02) begin bad++; $display("FAIL tie_cnt: got %h want 02", o_cnt); end
  endtask

  task automatic test_back_to_back();
    bit idle_ok;
    bit ids[6];
    int n, k = 0, last = 0, collide = 0, pd_bad = 0, gap_bad = 0;
    logic [7:0] exp_pd;
    apply_reset();
    i_data0 = 8'h30; i_data1 = 8'h40;
    i_req0 = 1'b1; i_req1 = 1'b1;
    for (int c = 0; c < 200 && k < 6; c++) begin
      @(negedge i_clk);
      if (o_ack0 && o_ack1) collide++;
      if (o_ack0 || o_ack1) begin
        ids[k] = o_ack1;
        exp_pd = o_ack1 ? i_data1 : i_data0;
        if (o_pd !== exp_pd) pd_bad++;
        if (k > 0 && (c - last) != 12) gap_bad++;
        last = c;
        k++;
        if (o_ack1) i_data1 = i_data1 + 8'd1;
        else        i_data0 = i_data0 + 8'd1;
      end
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    wait_idle(30, idle_ok, n);
    total++; if (k != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", k); end
    for (int i = 0; i < 6; i++) begin
      total++; if (ids[i] !== 1'(i % 2)) begin bad++; $display("FAIL b2b_id%0d: got %b want %0d", i, ids[i], i % 2); end
    end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL b2b_gap: got %0d bad gaps want 0", gap_bad); end
    total++; if (collide != 0) begin bad++; $display("FAIL b2b_ack_overlap: got %0d want 0", collide); end
    total++; if (pd_bad != 0) begin bad++; $display("FAIL b2b_pd: got %0d bad want 0", pd_bad); end
    total++; if (o_cnt !== 8'h06) begin bad++; $display("FAIL b2b_cnt: got %h want 06", o_cnt); end
  endtask

  task automatic test_idle_rdy_low();
    bit ok, id, idle_ok;
    int n, act = 0;
    apply_reset();
    rdy_mode = 2;
    repeat (2) @(negedge i_clk);
    i_data0 = 8'h3C; i_req0 = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      if (o_ack0 || o_ack1 || o_tr || o_state != 2'd0) act++;
    end
    total++; if (act != 0) begin bad++; $display("FAIL rdylow_idle: got %0d active cycles want 0", act); end
    rdy_mode = 0;
    wait_ack(20, ok, id);
    total++; if (!ok) begin bad++; $display("FAIL rdylow_release_ack: got none want ack"); end
    total++; if (o_pd !== 8'h3C) begin bad++; $display("FAIL rdylow_pd: got %h want 3c", o_pd); end
    i_req0 = 1'b0;
    wait_idle(30, idle_ok, n);
    total++; if (o_cnt !== 8'h01) begin bad++; $display("FAIL rdylow_cnt: got %h want 01", o_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok, id, idle_ok, prev_rdy, pre_grant_rdy;
    int n, saw_low = 0;
    apply_reset();
    i_data0 = 8'h5A; i_req0 = 1'b1;
    wait_ack(20, ok, id);
    i_req0 = 1'b0;
    for (int i = 0; i < 20 && o_state != 2'd3; i++) @(negedge i_clk);
    total++; if (o_state !== 2'd3) begin bad++; $display("FAIL rstmid_reach: got %0d want 3", o_state); end
    i_rst_n = 1'b0;
    #1;
    total++; if ({o_tr, o_ack0, o_ack1, o_busy, o_gnt_id, o_err} !== 6'b0) begin bad++; $display("FAIL rstmid_flags: got %b want 000000", {o_tr, o_ack0, o_ack1, o_busy, o_gnt_id, o_err}); end
    total++; if (o_pd !== 8'h00) begin bad++; $display("FAIL rstmid_pd: got %h want 00", o_pd); end
    total++; if (o_cnt !== 8'h00) begin bad++; $display("FAIL rstmid_cnt: got %h want 00", o_cnt); end
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL rstmid_state: got %0d want 0", o_state); end
    @(negedge i_clk);
    total++; if (o_ack0 || o_ack1) begin bad++; $display("FAIL rstmid_noack: got %b want 00", {o_ack0, o_ack1}); end
    i_rst_n = 1'b1;
    i_data1 = 8'h77; i_req1 = 1'b1;
    ok = 1'b0; id = 1'b0; pre_grant_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_rdy = i_rdy;
      if (!i_rdy) saw_low++;
      @(negedge i_clk);
      if (o_ack0 || o_ack1) begin
        ok = 1'b1; id = o_ack1; pre_grant_rdy = prev_rdy;
        break;
      end
    end
    total++; if (saw_low == 0) begin bad++; $display("FAIL rstmid_printer_busy: got 0 busy cycles want >0"); end
    total++; if (!ok) begin bad++; $display("FAIL rstmid_next_ack: got none want ack"); end
    total++; if (pre_grant_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_grant_rdy: got %b want 1", pre_grant_rdy); end
    total++; if (id !== 1'b1 || o_pd !== 8'h77) begin bad++; $display("FAIL rstmid_next: got id %b pd %h want id 1 pd 77", id, o_pd); end
    i_req1 = 1'b0;
    wait_idle(30, idle_ok, n);
    total++; if (o_cnt !== 8'h01) begin bad++; $display("FAIL rstmid_cnt_after: got %h want 01", o_cnt); end
  endtask

`ifdef PRN_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, id, idle_ok;
    int n;
    apply_reset();
    rdy_mode = 1;
    i_data0 = 8'hE7; i_req0 = 1'b1;
    wait_ack(20, ok, id);
    i_req0 = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL timeout_ack: got none want ack"); end
    wait_idle(40, idle_ok, n);
    total++; if (n != 5) begin bad++; $display("FAIL timeout_len: got %0d want 5", n); end
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", o_err); end
    total++; if (o_cnt !== 8'h00) begin bad++; $display("FAIL timeout_cnt: got %h want 00", o_cnt); end
    rdy_mode = 0;
    repeat (2) @(negedge i_clk);
  endtask
`else
  task automatic test_no_timeout();
    bit ok, id, idle_ok;
    int n;
    apply_reset();
    rdy_mode = 1;
    i_data0 = 8'hE7; i_req0 = 1'b1;
    wait_ack(20, ok, id);
    i_req0 = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL notimeout_ack: got none want ack"); end
    repeat (40) @(negedge i_clk);
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL notimeout_wait: got %0d want 2", o_state); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL notimeout_err: got %b want 0", o_err); end
    rdy_mode = 2;
    repeat (2) @(negedge i_clk);
    total++; if (o_state !== 2'd3) begin bad++; $display("FAIL notimeout_done: got %0d want 3", o_state); end
    rdy_mode = 0;
    wait_idle(20, idle_ok, n);
    total++; if (!idle_ok || o_cnt !== 8'h01) begin bad++; $display("FAIL notimeout_cnt: got %h idle %b want 01 idle 1", o_cnt, idle_ok); end
  endtask
`endif

  task automatic test_wrap();
    bit ok;
    int fails = 0;
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      do_xfer(1'(i % 2), 8'(i), ok);
      if (!ok) fails++;
    end
    total++; if (fails != 0) begin bad++; $display("FAIL wrap_xfers: got %0d failed want 0", fails); end
    total++; if (o_cnt !== 8'hFF) begin bad++; $display("FAIL wrap_preset: got %h want ff", o_cnt); end
    do_xfer(1'b1, 8'hC3, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_last_xfer: got fail want ok"); end
    total++; if (o_cnt !== 8'h00) begin bad++; $display("FAIL wrap_cnt: got %h want 00", o_cnt); end
  endtask

  initial begin
    i_rdy = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_idle_rdy_low();
    test_reset_mid();
`ifdef PRN_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prn_sched.md
PRN_SCHED -- requirements
Module: prn_sched

Interface
REQ-001 The block SHALL have the port `i_clk  in  1  system clock`; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `i_rst_n  in  1  asynchronous, active-low reset`.
REQ-003 The block SHALL have the port `i_req0  in  1  requester 0 print request`, held high until acknowledged.
REQ-004 The block SHALL have the port `i_data0  in  8  requester 0 byte`, stable while i_req0 is high.
REQ-005 The block SHALL have the port `o_ack0  out  1  one-cycle pulse: requester 0 byte accepted`.
REQ-006 The block SHALL have the ports `i_req1  in  1`, `i_data1  in  8` and `o_ack1  out  1`, with the same meaning for requester 1.
REQ-007 The block SHALL have the port `o_tr  out  1  printer transfer strobe`.
REQ-008 The block SHALL have the port `o_pd  out  8  printer data byte`.
REQ-009 The block SHALL have the port `i_rdy  in  1  printer ready (1 = idle)`.
REQ-010 The block SHALL have the port `o_busy  out  1  high whenever FSM is not IDLE`.
REQ-011 The block SHALL have the port `o_gnt_id  out  1  requester owning the current/last transfer`.
REQ-012 The block SHALL have the port `o_cnt  out  8  completed-byte counter`, wrapping 0xFF->0x00.
REQ-013 The block SHALL have the port `o_err  out  1  sticky printer-timeout flag`.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE, all registered.
REQ-015 In IDLE, if i_rdy=1 and any request is high, the FSM SHALL move to ISSUE at the next edge.
REQ-016 On the IDLE->ISSUE transition, the block SHALL set o_pd to the winner's data, o_gnt_id to the winner, and o_ack<winner> to 1.
REQ-017 o_ack0 and o_ack1 SHALL be registered, high only in the ISSUE cycle, and never both high at once.
REQ-018 Arbitration SHALL be round-robin: if only one requester is high, that requester wins; if both are high, the requester not granted last wins.
REQ-019 After reset, requester 0 SHALL win the first two-way tie.
REQ-020 o_tr SHALL be 1 only during the single ISSUE cycle; ISSUE SHALL go unconditionally to WAIT_BUSY.
REQ-021 WAIT_BUSY SHALL go to WAIT_DONE on the first edge where i_rdy=0.
REQ-022 WAIT_DONE SHALL go to IDLE on the first edge where i_rdy=1, and o_cnt SHALL increment on that same edge.
REQ-023 o_pd SHALL be held constant from ISSUE until the FSM returns to IDLE, because the printer samples data on every busy cycle.
REQ-024 Requests seen in any state other than IDLE SHALL be ignored and SHALL NOT be lost: the requester keeps its request high until acknowledged.
REQ-025 A request held across the ISSUE cycle (ack not yet seen by the requester) SHALL NOT cause a second grant.
REQ-026 With the standard 8-busy-cycle printer, the block SHALL take exactly 11 cycles from entering ISSUE to re-entering IDLE; back-to-back bytes SHALL therefore start every 12 cycles.
REQ-027 If i_rdy=0 while in IDLE, the FSM SHALL stay in IDLE and issue nothing.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately force: state IDLE, o_tr=0, o_pd=0x00, o_ack0/1=0, o_busy=0, o_gnt_id=0, o_cnt=0x00, o_err=0, and the round-robin pointer favouring requester 0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer without issuing an ack or incrementing the counter; the next grant after release SHALL require i_rdy=1.

Configuration
REQ-030 When the macro PRN_SCHED_TIMEOUT_EN is defined, a 5-bit watchdog SHALL run in WAIT_BUSY and WAIT_DONE.
REQ-031 With PRN_SCHED_TIMEOUT_EN defined: if i_rdy is not seen low within 4 cycles of entering WAIT_BUSY, or not seen high within 16 cycles of entering WAIT_DONE, the FSM SHALL go to IDLE, set o_err=1 (held until reset), and leave o_cnt unchanged.
REQ-032 With PRN_SCHED_TIMEOUT_EN undefined, the block SHALL contain no watchdog logic, SHALL tie o_err to 0, and the FSM SHALL wait indefinitely in WAIT_BUSY and WAIT_DONE.

Verification
REQ-033 The bench SHALL apply i_req0=1 with i_data0=0xA5 while idle, and SHALL check: o_ack0 and o_tr pulse together for 1 cycle; o_pd=0xA5 for 11 cycles; o_cnt=1; o_gnt_id=0.
REQ-034 The bench SHALL hold i_req0 and i_req1 high with 0x11 and 0x22 across two transfers after reset, and SHALL check the grant order 0 then 1, the printed sequence 0x11 then 0x22, and o_cnt=2.
REQ-035 The bench SHALL keep both requesters continuously high, re-presenting data after each ack, for 6 bytes, and SHALL check that grants alternate 0,1,0,1,0,1, that ISSUE cycles are exactly 12 cycles apart, and that o_ack0 and o_ack1 are never high together.
REQ-036 The bench SHALL preset o_cnt to 0xFF (255 transfers) and run one more transfer, and SHALL check that o_cnt wraps to 0x00.
REQ-037 The bench SHALL pulse i_rst_n low during WAIT_DONE, and SHALL check that all outputs reset immediately, that no ack is issued, and that the next request is served normally.
REQ-038 With PRN_SCHED_TIMEOUT_EN defined, the bench SHALL tie i_rdy to 1 and request one byte, and SHALL check that the FSM returns to IDLE 5 cycles after ISSUE with o_err=1 and o_cnt unchanged.
